// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the register-file write-port arbiter.
//   XLEN       - default datapath width
//   REG_W      - register index width
//   wb_entry_t - one buffered long-latency result {rd, val}
//   rd_onehot  - one-hot decode of a destination register index
package wb_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  val;
  } wb_entry_t;

  // One-hot decode of a destination index into a 32-bit register mask.
  function automatic logic [31:0] rd_onehot(input logic [REG_W-1:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small in-order buffer of wb_entry_t for long-latency results.
//   clk, rst    - clock, asynchronous active-low reset
//   push        - write push_entry at the tail (caller guarantees not full)
//   push_entry  - entry to enqueue
//   pop         - drop the head entry (caller guarantees not empty)
//   count       - number of valid entries
//   head        - oldest entry
//   ent_valid   - per-slot valid bits
//   ent_rd      - per-slot destination, used to build the pending mask
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_W-1:0]   ent_rd
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  wb_entry_t          mem_q   [DEPTH];
  wb_entry_t          mem_d   [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // Pop never hits the slot being pushed: push needs a free slot, pop a full one.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the buffer so pending entries are lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Per-slot destination view for the pending mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem_q[i].rd;
    end
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign ent_valid = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (always wins) and a buffered long-latency unit that drains
// on free slots.
//   clk, rst                  - clock, asynchronous active-low reset
//   wb_en, wb_rd, wb_val      - writeback-stage result
//   lu_valid, lu_ready,
//   lu_rd, lu_val             - long-latency result handshake
//   rf_we, rf_rd, rf_val      - registered register-file write port
//   pend_mask                 - destinations currently held in the buffer
//   stall_req                 - starvation stall request to the hazard unit
// Optional feature macro: WB_ARB_STARVE_EN enables the starvation counter;
// without it stall_req is tied low.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_val,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_val,
  output logic [31:0]     pend_mask,
  output logic            stall_req
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]            count_s;
  wb_entry_t                   head_s;
  wb_entry_t                   push_entry_s;
  logic [DEPTH-1:0]            ent_valid_s;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd_s;
  logic                        wb_take_s, pop_s, push_s;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_val_q, rf_val_d;
  // Holds lu_ready low while reset is asserted even though the buffer is empty.
  logic            ready_en_q, ready_en_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .count      (count_s),
    .head       (head_s),
    .ent_valid  (ent_valid_s),
    .ent_rd     (ent_rd_s)
  );

  // Ready uses only registered occupancy: no credit for a same-cycle pop.
  assign lu_ready = ready_en_q && (count_s < DEPTH_C);

  // Slot selection, accept/discard and next write-port values.
  always_comb begin
    wb_take_s    = wb_en && (wb_rd != 5'd0);
    pop_s        = !wb_take_s && (count_s != {CNT_W{1'b0}});
    // Writes to x0 are accepted and dropped here.
    push_s       = lu_valid && lu_ready && (lu_rd != 5'd0);
    push_entry_s = '{rd: lu_rd, val: lu_val};
    ready_en_d   = 1'b1;
    rf_we_d      = wb_take_s || pop_s;
    if (wb_take_s) begin
      rf_rd_d  = wb_rd;
      rf_val_d = wb_val;
    end else if (pop_s) begin
      rf_rd_d  = head_s.rd;
      rf_val_d = head_s.val;
    end else begin
      rf_rd_d  = rf_rd_q;
      rf_val_d = rf_val_q;
    end
  end

  // Write-port output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_val_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_val_q   <= rf_val_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_rd  = rf_rd_q;
  assign rf_val = rf_val_q;

  // Pending-destination mask over valid buffer entries; x0 never reported.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_s[i]) begin
        pend_mask = pend_mask | rd_onehot(ent_rd_s[i]);
      end else begin
        pend_mask = pend_mask;
      end
    end
    pend_mask[0] = 1'b0;
  end

`ifdef WB_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;

  // Wait counter: counts cycles the head is blocked, saturating at the limit.
  always_comb begin
    if (pop_s || (count_s == {CNT_W{1'b0}})) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (wait_q < LIMIT_C) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
    stall_d = (wait_d == LIMIT_C);
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif

endmodule
